// File: rtl/alu_issue_pkg.sv
// Shared constants, operand-source encoding and ALU op codes for the issue stage.
package alu_issue_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPS_W  = 7;
  localparam int unsigned CNT_W  = 32;

  // Where a resolved operand came from; ordered by increasing priority.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_e;

  // A subset of the ALU op codes driven toward execute.
  localparam logic [OPS_W-1:0] OP_ADD = 7'd1;
  localparam logic [OPS_W-1:0] OP_SUB = 7'd2;
  localparam logic [OPS_W-1:0] OP_AND = 7'd3;
  localparam logic [OPS_W-1:0] OP_OR  = 7'd4;
  localparam logic [OPS_W-1:0] OP_XOR = 7'd5;

endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Per-operand forwarding resolver: EX > MEM > WB > register file, x0 reads as zero.
module alu_issue_fwd_mux
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN   = alu_issue_pkg::XLEN,
  parameter int unsigned REG_AW = alu_issue_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              ex_ok,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              mem_ok,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   value,
  output fwd_sel_e          sel,
  output logic              hazard
);

  logic nonzero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign nonzero = (rs != '0);
  assign ex_hit  = nonzero && ex_valid  && (ex_rd  == rs);
  assign mem_hit = nonzero && mem_valid && (mem_rd == rs);
  assign wb_hit  = nonzero && wb_valid  && (wb_rd  == rs);

  // Pick the highest-priority source; only that source can raise a hazard.
  always_comb begin
    sel    = FWD_RF;
    value  = rf_data;
    hazard = 1'b0;
    if (!nonzero) begin
      value = '0;
    end else if (ex_hit) begin
      sel    = FWD_EX;
      value  = ex_data;
      hazard = !ex_ok;
    end else if (mem_hit) begin
      sel    = FWD_MEM;
      value  = mem_data;
      hazard = !mem_ok;
    end else if (wb_hit) begin
      sel   = FWD_WB;
      value = wb_data;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Decode->execute pipeline register with operand forwarding, load-use stall and flush.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN   = alu_issue_pkg::XLEN,
  parameter int unsigned REG_AW = alu_issue_pkg::REG_AW,
  parameter int unsigned OPS_W  = alu_issue_pkg::OPS_W,
  parameter int unsigned CNT_W  = alu_issue_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [XLEN-1:0]   dec_pc,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic [XLEN-1:0]   dec_rs1_data,
  input  logic [XLEN-1:0]   dec_rs2_data,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic              dec_use_imm,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [OPS_W-1:0]  dec_alu_ops,
  input  logic              ex_fwd_valid,
  input  logic [REG_AW-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0]   ex_fwd_data,
  input  logic              ex_fwd_ok,
  input  logic              mem_fwd_valid,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              mem_fwd_ok,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [OPS_W-1:0]  alu_ops,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [XLEN-1:0] rs1_res;
  logic [XLEN-1:0] rs2_res;
  fwd_sel_e        rs1_sel;
  fwd_sel_e        rs2_sel;
  logic            rs1_hz;
  logic            rs2_hz;
  logic            hazard;
  logic            accept;

  alu_issue_fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs1 (
    .rs        (dec_rs1),
    .rf_data   (dec_rs1_data),
    .ex_valid  (ex_fwd_valid),
    .ex_rd     (ex_fwd_rd),
    .ex_data   (ex_fwd_data),
    .ex_ok     (ex_fwd_ok),
    .mem_valid (mem_fwd_valid),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .mem_ok    (mem_fwd_ok),
    .wb_valid  (wb_fwd_valid),
    .wb_rd     (wb_fwd_rd),
    .wb_data   (wb_fwd_data),
    .value     (rs1_res),
    .sel       (rs1_sel),
    .hazard    (rs1_hz)
  );

  alu_issue_fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs2 (
    .rs        (dec_rs2),
    .rf_data   (dec_rs2_data),
    .ex_valid  (ex_fwd_valid),
    .ex_rd     (ex_fwd_rd),
    .ex_data   (ex_fwd_data),
    .ex_ok     (ex_fwd_ok),
    .mem_valid (mem_fwd_valid),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .mem_ok    (mem_fwd_ok),
    .wb_valid  (wb_fwd_valid),
    .wb_rd     (wb_fwd_rd),
    .wb_data   (wb_fwd_data),
    .value     (rs2_res),
    .sel       (rs2_sel),
    .hazard    (rs2_hz)
  );

  // Only in-flight EX/MEM producers can be unready; an unread operand never stalls.
  always_comb begin
    hazard = 1'b0;
    if (dec_use_rs1 && rs1_hz && (rs1_sel inside {FWD_EX, FWD_MEM})) hazard = 1'b1;
    if (dec_use_rs2 && rs2_hz && (rs2_sel inside {FWD_EX, FWD_MEM})) hazard = 1'b1;
  end

  assign dec_ready = !flush && !hazard && (!ex_valid || ex_ready);
  assign accept    = dec_valid && dec_ready;

  // Payload register: reset, then flush, then capture, then drain on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ops    <= '0;
      ex_rs2_val <= '0;
      ex_rd      <= '0;
      ex_pc      <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      alu_a      <= rs1_res;
      alu_b      <= dec_use_imm ? dec_imm : rs2_res;
      alu_ops    <= dec_alu_ops;
      ex_rs2_val <= rs2_res;
      ex_rd      <= dec_rd;
      ex_pc      <= dec_pc;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Saturating count of cycles decode was blocked, excluding flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (dec_valid && !dec_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with an expected-payload scoreboard queue.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [6:0]  ops;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_rs1_data, dec_rs2_data, dec_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_use_imm;
  logic [6:0]  dec_alu_ops;
  logic        ex_fwd_valid, mem_fwd_valid, wb_fwd_valid, ex_fwd_ok, mem_fwd_ok;
  logic [4:0]  ex_fwd_rd, mem_fwd_rd, wb_fwd_rd;
  logic [31:0] ex_fwd_data, mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_a, alu_b, ex_rs2_val, ex_pc;
  logic [6:0]  alu_ops;
  logic [4:0]  ex_rd;
  logic [CW-1:0] stall_cnt;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t held;

  always #5 clk = ~clk;

  alu_issue #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2), .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_rd(dec_rd), .dec_alu_ops(dec_alu_ops),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .ex_fwd_ok(ex_fwd_ok), .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data), .mem_fwd_ok(mem_fwd_ok), .wb_fwd_valid(wb_fwd_valid),
    .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_ops(alu_ops),
    .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_pc(ex_pc), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                         input logic uimm, input logic [4:0] rd, input logic [6:0] ops);
    dec_pc = pc; dec_rs1 = rs1; dec_rs1_data = d1; dec_rs2 = rs2; dec_rs2_data = d2;
    dec_imm = imm; dec_use_imm = uimm; dec_rd = rd; dec_alu_ops = ops;
    dec_use_rs1 = 1'b1; dec_use_rs2 = !uimm;
  endtask

  // Pop the oldest expected entry and compare the whole payload.
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_qnonempty"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_valid"}, 32'(ex_valid), 32'd1);
      chk({tag, "_a"}, alu_a, e.a);
      chk({tag, "_b"}, alu_b, e.b);
      chk({tag, "_rs2"}, ex_rs2_val, e.rs2);
      chk({tag, "_pc"}, ex_pc, e.pc);
      chk({tag, "_rd"}, 32'(ex_rd), 32'(e.rd));
      chk({tag, "_ops"}, 32'(alu_ops), 32'(e.ops));
    end
  endtask

  // Offer the currently driven instruction for one cycle, expecting it to be taken.
  task automatic issue(input exp_t e, input string tag);
    dec_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(dec_ready), 32'd1);
    q.push_back(e);
    tick();
    dec_valid = 1'b0;
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b1;
    set_dec(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 7'd0);
    ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0; ex_fwd_ok = 1'b1;
    mem_fwd_valid = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0; mem_fwd_ok = 1'b1;
    wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_ops", 32'(alu_ops), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_ready", 32'(dec_ready), 32'd1);

    // 1: register file + immediate
    set_dec(32'h100, 5'd3, 32'd10, 5'd0, 32'd77, 32'd5, 1'b1, 5'd1, OP_ADD);
    issue('{pc: 32'h100, a: 32'd10, b: 32'd5, rs2: 32'd0, rd: 5'd1, ops: OP_ADD}, "t1");
    tick();
    chk("t1_drain", 32'(ex_valid), 32'd0);

    // 2: forwarding priority and x0
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd4; ex_fwd_data = 32'd7;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'd9;
    set_dec(32'h200, 5'd4, 32'd1, 5'd0, 32'd0, 32'd3, 1'b1, 5'd2, OP_SUB);
    issue('{pc: 32'h200, a: 32'd7, b: 32'd3, rs2: 32'd0, rd: 5'd2, ops: OP_SUB}, "t2ex");
    ex_fwd_valid = 1'b0;
    set_dec(32'h204, 5'd4, 32'd1, 5'd0, 32'd0, 32'd3, 1'b1, 5'd2, OP_SUB);
    issue('{pc: 32'h204, a: 32'd9, b: 32'd3, rs2: 32'd0, rd: 5'd2, ops: OP_SUB}, "t2mem");
    mem_fwd_valid = 1'b0;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'd11;
    set_dec(32'h208, 5'd0, 32'd1, 5'd4, 32'd2, 32'd0, 1'b0, 5'd3, OP_AND);
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'hdead;
    issue('{pc: 32'h208, a: 32'd0, b: 32'd11, rs2: 32'd11, rd: 5'd3, ops: OP_AND}, "t2x0wb");
    ex_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;

    // 3: load-use hazard on rs2, lower-priority ready match does not mask it
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd2; ex_fwd_data = 32'h55; ex_fwd_ok = 1'b0;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd2; mem_fwd_data = 32'h66; mem_fwd_ok = 1'b1;
    set_dec(32'h300, 5'd0, 32'd0, 5'd2, 32'h99, 32'd0, 1'b0, 5'd6, OP_SUB);
    dec_use_rs2 = 1'b0;
    #1;
    chk("t3_unused_rdy", 32'(dec_ready), 32'd1);
    dec_use_rs2 = 1'b1;
    #1;
    chk("t3_hz_rdy", 32'(dec_ready), 32'd0);
    dec_valid = 1'b1;
    tick(); tick(); tick();
    chk("t3_cnt", 32'(stall_cnt), 32'd3);
    ex_fwd_ok = 1'b1;
    issue('{pc: 32'h300, a: 32'd0, b: 32'h55, rs2: 32'h55, rd: 5'd6, ops: OP_SUB}, "t3");
    chk("t3_cnt_after", 32'(stall_cnt), 32'd3);
    ex_fwd_valid = 1'b0; mem_fwd_valid = 1'b0;

    // 4: hold under backpressure, then back-to-back captures
    tick();
    ex_ready = 1'b0;
    set_dec(32'h400, 5'd5, 32'd50, 5'd6, 32'd60, 32'd0, 1'b0, 5'd7, OP_OR);
    held = '{pc: 32'h400, a: 32'd50, b: 32'd60, rs2: 32'd60, rd: 5'd7, ops: OP_OR};
    issue(held, "t4a");
    set_dec(32'h404, 5'd8, 32'd80, 5'd0, 32'd0, 32'd16, 1'b1, 5'd9, OP_XOR);
    dec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_hold_rdy", 32'(dec_ready), 32'd0);
      tick();
      chk("t4_hold_valid", 32'(ex_valid), 32'd1);
      chk("t4_hold_a", alu_a, held.a);
      chk("t4_hold_b", alu_b, held.b);
      chk("t4_hold_pc", ex_pc, held.pc);
    end
    chk("t4_cnt", 32'(stall_cnt), 32'd6);
    ex_ready = 1'b1;
    #1;
    chk("t4b_rdy", 32'(dec_ready), 32'd1);
    q.push_back('{pc: 32'h404, a: 32'd80, b: 32'd16, rs2: 32'd0, rd: 5'd9, ops: OP_XOR});
    tick();
    set_dec(32'h408, 5'd1, 32'd100, 5'd2, 32'd200, 32'd0, 1'b0, 5'd10, OP_ADD);
    check_out("t4b");
    #1;
    chk("t4c_rdy", 32'(dec_ready), 32'd1);
    q.push_back('{pc: 32'h408, a: 32'd100, b: 32'd200, rs2: 32'd200, rd: 5'd10, ops: OP_ADD});
    tick();
    dec_valid = 1'b0;
    check_out("t4c");

    // 5: flush drops both held and incoming entries
    ex_ready = 1'b0;
    set_dec(32'h500, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 5'd11, OP_AND);
    dec_valid = 1'b1; flush = 1'b1;
    #1;
    chk("t5_rdy", 32'(dec_ready), 32'd0);
    tick();
    flush = 1'b0; dec_valid = 1'b0;
    chk("t5_valid", 32'(ex_valid), 32'd0);
    chk("t5_cnt", 32'(stall_cnt), 32'd6);

    // stall counter saturation
    ex_ready = 1'b1;
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd2; ex_fwd_ok = 1'b0;
    dec_valid = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("sat_cnt", 32'(stall_cnt), 32'd15);
    dec_valid = 1'b0; ex_fwd_valid = 1'b0; ex_fwd_ok = 1'b1;

    // 6: reset with an entry in flight
    set_dec(32'h600, 5'd3, 32'd33, 5'd4, 32'd44, 32'd0, 1'b0, 5'd12, OP_SUB);
    issue('{pc: 32'h600, a: 32'd33, b: 32'd44, rs2: 32'd44, rd: 5'd12, ops: OP_SUB}, "t6");
    ex_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", 32'(ex_valid), 32'd0);
    chk("t6_a", alu_a, 32'd0);
    chk("t6_b", alu_b, 32'd0);
    chk("t6_rs2", ex_rs2_val, 32'd0);
    chk("t6_pc", ex_pc, 32'd0);
    chk("t6_rd", 32'(ex_rd), 32'd0);
    chk("t6_ops", 32'(alu_ops), 32'd0);
    chk("t6_cnt", 32'(stall_cnt), 32'd0);
    chk("q_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
